seg7_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver for board-level debug and status readouts. It scans DIGITS common-anode/cathode digits from a packed hex value and adds several features:
- per-digit decimal points;
- leading-zero blanking;
- anti-ghosting dead time between digits;
- tear-free frame snapshots of the inputs;
- optional PWM brightness control.

It sits between any counter or status register and the board's segment/digit pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/seg7_font_decode.sv | 22 ++
 rtl/seg7_scan_driver.sv | 190 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan driver.
//   FONT           : 16-entry hex glyph table, active-high, bit 0 = segment a
//   SEG_A..SEG_DP  : bit positions inside the 8-bit segment bus
//   inactive_level : pin level that means "off" for a given polarity setting
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry n holds the glyph for hex digit n (entry 0 sits in the low bits).
  localparam logic [15:0][6:0] FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // An active-low pin is off when high; an active-high pin is off when low.
  function automatic logic inactive_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundle between a display client and the scan driver.
//   value/dp/blank_lz/brightness : display request (client -> driver)
//   segment/digit/frame_start    : board pin drive and frame marker (driver -> client)
// Modports: master = client side, slave = driver side.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                blank_lz;
  logic [3:0]          brightness;
  logic [7:0]          segment;
  logic [DIGITS-1:0]   digit;
  logic                frame_start;

  modport master (
    output value, dp, blank_lz, brightness,
    input  segment, digit, frame_start
  );

  modport slave (
    input  value, dp, blank_lz, brightness,
    output segment, digit, frame_start
  );
endinterface

// File: rtl/seg7_font_decode.sv
// seg7_font_decode: combinational hex-to-glyph lookup.
//   nibble : hex digit to show
//   blank  : 1 forces an empty glyph
//   glyph  : active-high segments a..g (bit 0 = a)
module seg7_font_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] glyph
);

  // Glyph lookup with blanking override.
  always_comb begin
    if (blank) begin
      glyph = 7'h00;
    end else begin
      glyph = FONT[nibble];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment scanner.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : seg7_scan_driver_if.slave (value, dp, blank_lz, brightness in;
//           segment, digit, frame_start out, all outputs registered)
// Each digit owns a slot of SCAN_DIV cycles; the first BLANK_CYCLES of a slot
// keep every digit off to avoid ghosting. Inputs are sampled once per frame.
// Optional feature macro: SEG7_DIM_EN adds 16-step PWM brightness on the
// digit enables.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 65536,
  parameter int BLANK_CYCLES   = 16,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_DIG = 1
) (
  input logic              clk,
  input logic              reset,
  seg7_scan_driver_if.slave bus
);

  localparam int S_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [S_W-1:0]    S_LAST   = S_W'(SCAN_DIV - 1);
  localparam logic [S_W-1:0]    S_BLANK  = S_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = {8{inactive_level(ACTIVE_LOW_SEG)}};
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{inactive_level(ACTIVE_LOW_DIG)}};

  logic [S_W-1:0]      s_q, s_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] value_sh_q, value_sh_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic                blz_sh_q, blz_sh_d;
  logic [7:0]          segment_q, segment_d;
  logic [DIGITS-1:0]   digit_q, digit_d;
  logic                frame_start_q, frame_start_d;

  logic [DIGITS-1:0]   lz_blank_s;
  logic [DIGITS-1:0]   dig_onehot_s;
  logic [3:0]          cur_nibble_s;
  logic                cur_dp_s;
  logic                cur_blank_s;
  logic [6:0]          glyph_s;
  logic [7:0]          seg_on_s;
  logic                lit_s;
  logic                pwm_on_s;

`ifdef SEG7_DIM_EN
  logic [3:0] bright_sh_q, bright_sh_d;
  logic [3:0] p_q, p_d;
  logic [3:0] p_cur_s;
`else
  logic brightness_unused;
  assign brightness_unused = ^bus.brightness;
`endif

  // Slot/digit counters and the once-per-frame input snapshot.
  always_comb begin
    s_d        = s_q;
    idx_d      = idx_q;
    value_sh_d = value_sh_q;
    dp_sh_d    = dp_sh_q;
    blz_sh_d   = blz_sh_q;
`ifdef SEG7_DIM_EN
    bright_sh_d = bright_sh_q;
`endif
    if (s_q == S_LAST) begin
      s_d = '0;
      if (idx_q == IDX_LAST) begin
        // Last cycle of the frame: the next frame sees a coherent input set.
        idx_d      = '0;
        value_sh_d = bus.value;
        dp_sh_d    = bus.dp;
        blz_sh_d   = bus.blank_lz;
`ifdef SEG7_DIM_EN
        bright_sh_d = bus.brightness;
`endif
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      s_d = s_q + 1'b1;
    end
  end

  // Leading-zero detection: walk down from the top digit while nibbles stay zero.
  always_comb begin
    logic zeros_above;
    zeros_above = 1'b1;
    lz_blank_s  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeros_above   = zeros_above & (value_sh_q[4*i +: 4] == 4'h0);
      lz_blank_s[i] = blz_sh_q & zeros_above & (i != 0);
    end
  end

  // Select the current digit's nibble, dp and blank flag; build the one-hot enable.
  always_comb begin
    cur_nibble_s = 4'h0;
    cur_dp_s     = 1'b0;
    cur_blank_s  = 1'b0;
    dig_onehot_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_onehot_s[i] = (idx_q == IDX_W'(i));
      cur_nibble_s    = cur_nibble_s | (dig_onehot_s[i] ? value_sh_q[4*i +: 4] : 4'h0);
      cur_dp_s        = cur_dp_s | (dig_onehot_s[i] & dp_sh_q[i]);
      cur_blank_s     = cur_blank_s | (dig_onehot_s[i] & lz_blank_s[i]);
    end
  end

  seg7_font_decode u_font (
    .nibble (cur_nibble_s),
    .blank  (cur_blank_s),
    .glyph  (glyph_s)
  );

`ifdef SEG7_DIM_EN
  // PWM phase restarts at the first lit cycle so every digit gets the same duty.
  always_comb begin
    if (s_q == S_BLANK) begin
      p_cur_s = 4'h0;
    end else begin
      p_cur_s = p_q;
    end
    if (lit_s) begin
      p_d = p_cur_s + 4'h1;
    end else begin
      p_d = p_q;
    end
    pwm_on_s = (p_cur_s <= bright_sh_q);
  end
`else
  assign pwm_on_s = 1'b1;
`endif

  // Next output values; polarity is applied by XOR with the "off" level.
  always_comb begin
    seg_on_s              = 8'h00;
    seg_on_s[SEG_G:SEG_A] = glyph_s;
    seg_on_s[SEG_DP]      = cur_dp_s;
    lit_s                 = (s_q >= S_BLANK);
    frame_start_d         = (s_q == '0) && (idx_q == '0);
    if (lit_s) begin
      segment_d = seg_on_s ^ SEG_OFF;
      digit_d   = (pwm_on_s ? dig_onehot_s : '0) ^ DIG_OFF;
    end else begin
      segment_d = SEG_OFF;
      digit_d   = DIG_OFF;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q           <= '0;
      idx_q         <= '0;
      value_sh_q    <= '0;
      dp_sh_q       <= '0;
      blz_sh_q      <= 1'b0;
      segment_q     <= SEG_OFF;
      digit_q       <= DIG_OFF;
      frame_start_q <= 1'b0;
`ifdef SEG7_DIM_EN
      bright_sh_q   <= 4'h0;
      p_q           <= 4'h0;
`endif
    end else begin
      s_q           <= s_d;
      idx_q         <= idx_d;
      value_sh_q    <= value_sh_d;
      dp_sh_q       <= dp_sh_d;
      blz_sh_q      <= blz_sh_d;
      segment_q     <= segment_d;
      digit_q       <= digit_d;
      frame_start_q <= frame_start_d;
`ifdef SEG7_DIM_EN
      bright_sh_q   <= bright_sh_d;
      p_q           <= p_d;
`endif
    end
  end

  assign bus.segment     = segment_q;
  assign bus.digit       = digit_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver with
// DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low pins.
// Honours SEG7_DIM_EN when the design is built with it.
module tb_seg7_scan_driver;

  localparam int MAXE = 4096;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;

  logic [15:0] cur_val;
  logic [3:0]  cur_dp;
  logic        cur_blz;
  logic [3:0]  cur_br;

  logic [15:0] hv   [MAXE];
  logic [3:0]  hdp  [MAXE];
  logic        hblz [MAXE];
  logic [3:0]  hbr  [MAXE];

  exp_t sb_q [$];
  int   sb_m [$];
  exp_t last_exp;

  logic [6:0] font_tb [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] masks [4] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};

  seg7_scan_driver_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
    .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected pins for output cycle m given the frame's displayed inputs.
  function automatic exp_t model(int m, logic [15:0] v, logic [3:0] d, logic blz, logic [3:0] br);
    exp_t r;
    int slot, s;
    logic [15:0] upper;
    logic [3:0] nib, oh;
    logic [6:0] glyph;
    logic on;
    slot = (m / 8) % 4;
    s    = m % 8;
    r.fs = (m % 32 == 0);
    if (s < 2) begin
      r.seg = 8'hFF;
      r.dig = 4'hF;
    end else begin
      upper = v >> (4 * slot);
      nib   = upper[3:0];
      glyph = (blz && slot > 0 && upper == 16'h0) ? 7'h00 : font_tb[nib];
      r.seg = ~{d[slot], glyph};
      on = 1'b1;
`ifdef SEG7_DIM_EN
      on = ((s - 2) % 16) <= int'(br);
`endif
      oh    = 4'b0001 << slot;
      r.dig = on ? ~oh : 4'hF;
    end
    return r;
  endfunction

  task automatic set_in(logic [15:0] v, logic [3:0] d, logic blz, logic [3:0] br);
    cur_val = v; cur_dp = d; cur_blz = blz; cur_br = br;
    bus.value = v; bus.dp = d; bus.blank_lz = blz; bus.brightness = br;
  endtask

  // One clock: log the inputs seen at this edge and queue the expected output.
  task automatic tick();
    exp_t e;
    int j;
    @(posedge clk);
    k++;
    hv[k] = cur_val; hdp[k] = cur_dp; hblz[k] = cur_blz; hbr[k] = cur_br;
    #1;
    j = (k - 1) / 32;
    if (j == 0) e = model(k - 1, 16'h0, 4'h0, 1'b0, 4'h0);
    else        e = model(k - 1, hv[32*j], hdp[32*j], hblz[32*j], hbr[32*j]);
    sb_q.push_back(e);
    sb_m.push_back(k - 1);
    last_exp = e;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      if (k < MAXE - 1) tick();
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every output cycle is compared against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    int m;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      m = sb_m.pop_front();
      checks++;
      if ({bus.segment, bus.digit, bus.frame_start} !== e) begin
        failures++;
        $display("FAIL scan m=%0d actual seg=%h dig=%h fs=%b expected seg=%h dig=%h fs=%b",
                 m, bus.segment, bus.digit, bus.frame_start, e.seg, e.dig, e.fs);
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_in(16'h1234, 4'h0, 1'b0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digit", 32'(bus.digit), 32'h0000000F);
    chk("reset_segment", 32'(bus.segment), 32'h000000FF);
    chk("reset_frame_start", 32'(bus.frame_start), 32'h00000000);
    reset = 1'b0;

    // Zeroed first frame, then 1234.
    run(96);
    // Leading-zero blanking.
    set_in(16'h0007, 4'h0, 1'b1, 4'hF);
    run(96);
    set_in(16'h0000, 4'h0, 1'b1, 4'hF);
    run(96);
    // Mid-frame change lands in the next frame only.
    set_in(16'hAAAA, 4'h0, 1'b0, 4'hF);
    run(64);
    while ((k % 32) != 20 && k < MAXE - 1) tick();
    set_in(16'h5555, 4'h0, 1'b0, 4'hF);
    run(96);
    // Decimal point survives a blanked glyph.
    set_in(16'h0000, 4'b0100, 1'b1, 4'hF);
    run(96);
    // Brightness extremes.
    set_in(16'h89CE, 4'b1001, 1'b0, 4'h1);
    run(96);
    set_in(16'h89CE, 4'b1001, 1'b0, 4'hF);
    run(96);
    set_in(16'h89CE, 4'b1001, 1'b0, 4'h0);
    run(96);

    // Randomised inputs, biased toward leading zeros.
    for (int i = 0; i < 1400; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_in(16'($urandom) & masks[$urandom_range(0, 3)], 4'($urandom),
               1'($urandom), 4'($urandom_range(0, 15)));
      if (k < MAXE - 1) tick();
    end

    // Settle on full brightness, then reset inside a lit cycle.
    set_in(16'h4321, 4'h0, 1'b0, 4'hF);
    run(64);
    for (int i = 0; i < 16; i++) begin
      if (((k - 1) % 8) == 4) break;
      if (k < MAXE - 1) tick();
    end

    for (int i = 0; i < 4; i++) begin
      if (sb_q.size() > 0) @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", sb_q.size());
    end

    #1;
    chk("pre_reset_lit_digit", 32'(bus.digit), 32'(last_exp.dig));
    reset = 1'b1;
    #1;
    chk("async_reset_digit", 32'(bus.digit), 32'h0000000F);
    chk("async_reset_segment", 32'(bus.segment), 32'h000000FF);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
